// File: rtl/hilo_mdu_if.sv
// Decoder-facing bundle of the HI/LO multiply-divide unit: op select, operands,
// flush, and the start/busy/read-data responses.
interface hilo_mdu_if;
   logic [3:0]  HILOOp;
   logic [31:0] A;
   logic [31:0] B;
   logic        Req;
   logic        Start;
   logic        Busy;
   logic [31:0] HILO_out;

   modport master (output HILOOp, A, B, Req, input Start, Busy, HILO_out);
   modport slave  (input HILOOp, A, B, Req, output Start, Busy, HILO_out);
endinterface

// File: rtl/hilo_mdu.sv
// MIPS-style HI/LO multiply/divide unit: fixed-latency mult/div commit into HI/LO,
// plus mthi/mtlo writes and combinational mfhi/mflo reads.
module hilo_mdu #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input logic        clk,
   input logic        reset,
   hilo_mdu_if.slave  mdu
);
   localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

   localparam logic [3:0] OP_MFHI = 4'd4;
   localparam logic [3:0] OP_MTHI = 4'd5;
   localparam logic [3:0] OP_MFLO = 4'd6;
   localparam logic [3:0] OP_MTLO = 4'd7;

   logic [31:0]      hi_q, hi_d, lo_q, lo_d;
   logic [31:0]      a_q, b_q;
   logic [1:0]       op_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic        busy, start_c;
   logic        signed_op, dbz;
   logic [63:0] sext_a, sext_b, prod;
   logic [31:0] mag_a, mag_b, divisor, q_mag, r_mag, quo, rem;

   assign busy    = (cnt_q != '0);
   assign start_c = (mdu.HILOOp[3:2] == 2'b00) & ~busy & ~mdu.Req;

   assign mdu.Start    = start_c;
   assign mdu.Busy     = busy;
   assign mdu.HILO_out = (mdu.HILOOp == OP_MFHI) ? hi_q :
                         (mdu.HILOOp == OP_MFLO) ? lo_q : 32'd0;

   // Result datapath: one 64-bit multiplier, one unsigned divider on magnitudes.
   always_comb begin
      signed_op = ~op_q[0];
      sext_a    = signed_op ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
      sext_b    = signed_op ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
      prod      = sext_a * sext_b;

      mag_a   = (signed_op && a_q[31]) ? (32'd0 - a_q) : a_q;
      mag_b   = (signed_op && b_q[31]) ? (32'd0 - b_q) : b_q;
      dbz     = (b_q == 32'd0);
      divisor = dbz ? 32'd1 : mag_b;
      q_mag   = mag_a / divisor;
      r_mag   = mag_a % divisor;
      // Quotient truncates toward zero; remainder follows the dividend's sign.
      quo     = (signed_op && (a_q[31] ^ b_q[31])) ? (32'd0 - q_mag) : q_mag;
      rem     = (signed_op && a_q[31]) ? (32'd0 - r_mag) : r_mag;
   end

   // Next-state for HI/LO and the busy counter.
   always_comb begin
      hi_d  = hi_q;
      lo_d  = lo_q;
      cnt_d = cnt_q;
      if (start_c) begin
         cnt_d = mdu.HILOOp[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end else if (busy) begin
         cnt_d = cnt_q - CNT_W'(1);
      end

      if (cnt_q == CNT_W'(1)) begin
         if (!op_q[1]) begin
            {hi_d, lo_d} = prod;
         end else if (!dbz) begin
            hi_d = rem;
            lo_d = quo;
         end
      end else if (!busy && !mdu.Req) begin
         if (mdu.HILOOp == OP_MTHI) hi_d = mdu.A;
         if (mdu.HILOOp == OP_MTLO) lo_d = mdu.A;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hi_q  <= '0;
         lo_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         op_q  <= '0;
         cnt_q <= '0;
      end else begin
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         cnt_q <= cnt_d;
         if (start_c) begin
            a_q  <= mdu.A;
            b_q  <= mdu.B;
            op_q <= mdu.HILOOp[1:0];
         end
      end
   end
endmodule

// File: tb/tb_hilo_mdu.sv
// Bench for hilo_mdu: table of md vectors, random vectors against a longint model,
// and hand sequences for back-to-back, divide-by-zero, flush and reset corners.
module tb_hilo_mdu;
   localparam int unsigned MULT_N = 5;
   localparam int unsigned DIV_N  = 10;

   localparam logic [3:0] OP_MULT = 4'd0;
   localparam logic [3:0] OP_MULTU = 4'd1;
   localparam logic [3:0] OP_DIV  = 4'd2;
   localparam logic [3:0] OP_DIVU = 4'd3;
   localparam logic [3:0] OP_MFHI = 4'd4;
   localparam logic [3:0] OP_MTHI = 4'd5;
   localparam logic [3:0] OP_MFLO = 4'd6;
   localparam logic [3:0] OP_MTLO = 4'd7;
   localparam logic [3:0] OP_NONE = 4'd8;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
   } res_t;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   logic clk = 1'b0;
   logic reset;

   hilo_mdu_if bus ();

   hilo_mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk   (clk),
      .reset (reset),
      .mdu   (bus)
   );

   always #5 clk = ~clk;

   res_t        sb_q[$];
   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] cur_hi = '0;
   logic [31:0] cur_lo = '0;
   vec_t        tbl[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   function automatic res_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      res_t   r;
      longint sa, sb, p, q, m;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      r  = '0;
      case (op)
         OP_MULT: begin
            p = sa * sb;
            r = res_t'(p);
         end
         OP_MULTU: r = res_t'({32'd0, a} * {32'd0, b});
         OP_DIV: begin
            q = sa / sb;
            m = sa % sb;
            r.hi = m[31:0];
            r.lo = q[31:0];
         end
         default: begin
            r.hi = a % b;
            r.lo = a / b;
         end
      endcase
      return r;
   endfunction

   // Present an md op; optionally wait for the next negedge first.
   task automatic start_md(input bit sync, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic req, input bit push, input res_t exp);
      if (sync) @(negedge clk);
      bus.HILOOp = op;
      bus.A      = a;
      bus.B      = b;
      bus.Req    = req;
      #1;
      check("start", 32'(bus.Start), 32'(!req));
      if (!req && push) sb_q.push_back(exp);
   endtask

   // Count busy cycles, driving bop/ba/breq while busy; returns in the first idle cycle.
   task automatic wait_idle(input int exp_n, input logic [3:0] bop, input logic [31:0] ba,
                            input logic breq);
      int n    = 0;
      bit done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         #1;
         if (bus.Busy) begin
            n++;
            bus.HILOOp = bop;
            bus.A      = ba;
            bus.Req    = breq;
            if (bop <= OP_DIVU) begin
               #1;
               check("start_while_busy", 32'(bus.Start), 32'd0);
            end
         end else begin
            bus.HILOOp = OP_NONE;
            bus.Req    = 1'b0;
            done       = 1'b1;
         end
      end
      if (!done) begin
         n_vec++;
         n_err++;
         $display("FAIL busy_timeout: got busy after 200 cycles required idle");
      end
      check("busy_cycles", 32'(n), 32'(exp_n));
   endtask

   task automatic read_check(input string tag, input logic [31:0] hi, input logic [31:0] lo);
      bus.HILOOp = OP_MFHI;
      #1;
      check({tag, " hi"}, bus.HILO_out, hi);
      bus.HILOOp = OP_MFLO;
      #1;
      check({tag, " lo"}, bus.HILO_out, lo);
      bus.HILOOp = OP_NONE;
   endtask

   task automatic pop_check(input string tag);
      res_t e;
      @(negedge clk);
      if (sb_q.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL %s: got empty scoreboard required one entry", tag);
      end else begin
         e = sb_q.pop_front();
         read_check(tag, e.hi, e.lo);
         cur_hi = e.hi;
         cur_lo = e.lo;
      end
   endtask

   task automatic run_md(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input res_t exp);
      start_md(1'b1, op, a, b, 1'b0, 1'b1, exp);
      wait_idle(op[1] ? DIV_N : MULT_N, OP_NONE, 32'd0, 1'b0);
      pop_check(tag);
   endtask

   task automatic mt(input logic [3:0] op, input logic [31:0] a);
      @(negedge clk);
      bus.HILOOp = op;
      bus.A      = a;
      bus.Req    = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{OP_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA};
      tbl[1] = '{OP_MULTU, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA};
      tbl[2] = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
      tbl[3] = '{OP_DIVU,  32'd7,        32'd2,        32'd1,        32'd3};
      tbl[4] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
      tbl[5] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
      tbl[6] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      tbl[7] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      tbl[8] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};

      reset      = 1'b1;
      bus.HILOOp = OP_NONE;
      bus.A      = '0;
      bus.B      = '0;
      bus.Req    = 1'b0;
      #1;
      check("reset busy", 32'(bus.Busy), 32'd0);
      read_check("reset", 32'd0, 32'd0);
      bus.HILOOp = OP_MULT;
      #1;
      check("start_in_reset", 32'(bus.Start), 32'd1);
      bus.HILOOp = OP_NONE;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 9; i++)
         run_md($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, {tbl[i].hi, tbl[i].lo});

      // Non-read ops must read back zero.
      @(negedge clk);
      bus.HILOOp = OP_NONE;
      #1;
      check("out_none", bus.HILO_out, 32'd0);
      bus.HILOOp = 4'd15;
      #1;
      check("out_op15", bus.HILO_out, 32'd0);
      bus.HILOOp = OP_NONE;

      for (int i = 0; i < 6; i++) begin
         logic [3:0]  op;
         logic [31:0] a, b;
         op = 4'($urandom_range(0, 3));
         a  = $urandom;
         b  = $urandom;
         if (op[1] && (i % 2 == 1)) b = {24'd0, b[7:0]};
         if (b == 32'd0) b = 32'd1;
         run_md($sformatf("rnd%0d", i), op, a, b, model(op, a, b));
      end

      // Back-to-back: new op accepted in the first idle cycle; old result readable while busy.
      start_md(1'b1, OP_MULTU, 32'd5, 32'd7, 1'b0, 1'b1, {32'd0, 32'd35});
      wait_idle(MULT_N, OP_NONE, 32'd0, 1'b0);
      start_md(1'b0, OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b1, {32'd2, 32'd14});
      pop_check("b2b_first");
      wait_idle(DIV_N - 1, OP_NONE, 32'd0, 1'b0);
      pop_check("b2b_second");

      // mthi/mtlo, then divide by zero with an ignored mthi during busy.
      mt(OP_MTHI, 32'h1234);
      mt(OP_MTLO, 32'h5678);
      start_md(1'b1, OP_DIVU, 32'h99, 32'd0, 1'b0, 1'b1, {32'h1234, 32'h5678});
      wait_idle(DIV_N, OP_MTHI, 32'hDEAD, 1'b0);
      pop_check("div0");

      // Flushed mult and flushed mthi have no effect.
      start_md(1'b1, OP_MULT, 32'd2, 32'd3, 1'b1, 1'b0, '0);
      @(negedge clk);
      bus.HILOOp = OP_NONE;
      bus.Req    = 1'b0;
      #1;
      check("flush busy", 32'(bus.Busy), 32'd0);
      read_check("flush", cur_hi, cur_lo);
      @(negedge clk);
      bus.HILOOp = OP_MTHI;
      bus.A      = 32'hBAD;
      bus.Req    = 1'b1;
      @(negedge clk);
      bus.HILOOp = OP_NONE;
      bus.Req    = 1'b0;
      #1;
      read_check("mthi_req", cur_hi, cur_lo);

      // Req during busy does not abort.
      start_md(1'b1, OP_MULT, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b1, {32'h3FFFFFFF, 32'h00000001});
      wait_idle(MULT_N, OP_NONE, 32'd0, 1'b1);
      pop_check("req_busy");

      // Asynchronous reset mid-operation.
      start_md(1'b1, OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, '0);
      @(negedge clk);
      bus.HILOOp = OP_NONE;
      repeat (2) @(negedge clk);
      #1;
      check("busy_before_reset", 32'(bus.Busy), 32'd1);
      reset = 1'b1;
      #1;
      check("reset_mid busy", 32'(bus.Busy), 32'd0);
      read_check("reset_mid", 32'd0, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      start_md(1'b0, OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, {32'hFFFFFFFE, 32'h00000001});
      wait_idle(MULT_N, OP_NONE, 32'd0, 1'b0);
      pop_check("after_reset");

      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/hilo_mdu.md
HILO_MDU -- requirements
Module: hilo_mdu

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, meaning the number of Busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, meaning the number of Busy cycles for div/divu.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port HILOOp, input, 4 bits: operation select from the decoder.
- 0 = mult, 1 = multu, 2 = div, 3 = divu
- 4 = mfhi, 5 = mthi, 6 = mflo, 7 = mtlo
- 8 and all other values = none
REQ-006 SHALL have port A, input, 32 bits: forwarded rs value.
REQ-007 SHALL have port B, input, 32 bits: forwarded rt value.
REQ-008 SHALL have port Req, input, 1 bit: exception/interrupt flush; the instruction currently in this stage is cancelled.
REQ-009 SHALL have port Start, output, 1 bit: a mult/multu/div/divu is being accepted this cycle.
REQ-010 SHALL have port Busy, output, 1 bit: an operation is in flight.
REQ-011 SHALL have port HILO_out, output, 32 bits: read data for mfhi/mflo.

Function
REQ-012 Start SHALL be combinational and equal to (HILOOp in 0..3) & !Busy & !Req.
REQ-013 On a clock edge with Start=1, the block SHALL:
- latch A and B;
- latch the operation;
- load an internal counter with MULT_CYCLES (ops 0/1) or DIV_CYCLES (ops 2/3).
REQ-014 Busy SHALL equal (counter != 0); the counter SHALL decrement by 1 on each edge while nonzero. Busy is therefore high for exactly N cycles after the start edge.
REQ-015 On the edge where the counter goes 1->0, HI and LO SHALL be written with the result. The new values are readable in the first cycle Busy=0.
REQ-016 mult SHALL produce {HI,LO} = signed 64-bit product of A and B.
REQ-017 multu SHALL produce {HI,LO} = unsigned 64-bit product of A and B.
REQ-018 div SHALL produce LO = signed quotient truncated toward zero and HI = remainder, which takes the sign of the dividend.
REQ-019 divu SHALL produce the unsigned quotient in LO and the unsigned remainder in HI.
REQ-020 Divide by zero (div or divu with B=0) SHALL run the full DIV_CYCLES and leave HI and LO unchanged.
REQ-021 div of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-022 mthi SHALL write HI=A, and mtlo SHALL write LO=A, on the edge where the op is present and Busy=0 and Req=0.
REQ-023 HILO_out SHALL be combinational:
- HI when HILOOp=4;
- LO when HILOOp=6;
- 0 otherwise.
HILO_out reflects the current register values and does not depend on Busy.
REQ-024 Any HILOOp presented while Busy=1 SHALL be ignored, with no state change. Upstream stall logic guarantees md/mt/mf is held off while Start|Busy.
REQ-025 Req=1 SHALL suppress Start and mthi/mtlo writes in that cycle.
REQ-026 Req=1 SHALL NOT abort an operation already in flight; it completes and commits per REQ-015.
REQ-027 A new md op presented in the cycle Busy falls SHALL be accepted that cycle. Its operands see no hazard, since HI/LO are already updated.

Reset
REQ-028 Asynchronous assertion of reset SHALL immediately clear HI, LO, the counter and the latched operands/op to 0, giving Busy=0.
REQ-029 Start and HILO_out SHALL then follow REQ-012/REQ-023 from the cleared state.
REQ-030 Reset asserted mid-operation SHALL discard that operation; HI/LO remain 0 after reset release.
REQ-031 After reset deassertion, the first edge SHALL accept a new operation normally.

Verification
REQ-032 Signed multiply:
- stimulus: mult, A=0xFFFFFFFE, B=3;
- response: Start=1 for 1 cycle, Busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; mfhi/mflo return these values.
REQ-033 Signed divide:
- stimulus: div, A=0xFFFFFFF9 (-7), B=2;
- response: Busy high for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- stimulus: divu, A=7, B=2;
- response: LO=3, HI=1.
REQ-034 Divide by zero, then move-to:
- stimulus: mthi A=0x1234 and mtlo A=0x5678 on consecutive cycles, then divu with B=0;
- response: HI=0x1234 and LO=0x5678 persist after the 10 Busy cycles.
REQ-035 Flush and busy interaction:
- stimulus: mult with Req=1;
- response: Start=0, Busy stays 0, HI/LO unchanged.
- stimulus: mthi while Busy=1;
- response: ignored.
REQ-036 Reset mid-operation:
- stimulus: reset asserted 3 cycles into a multu of 0xFFFFFFFF x 0xFFFFFFFF;
- response: Busy=0 and HI=LO=0 immediately, without waiting for a clock edge.
- stimulus: the same multu after reset release;
- response: HI=0xFFFFFFFE, LO=0x00000001.
